// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared execute-stage encodings and the EX/MEM register layout
package riscv_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam logic [1:0] SEL1_RS1 = 2'd0;
    localparam logic [1:0] SEL1_PC  = 2'd1;
    localparam logic [1:0] SEL2_RS2 = 2'd0;
    localparam logic [1:0] SEL2_IMM = 2'd1;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] store_data;
        logic [DATA_WIDTH-1:0] pc4;
        logic [4:0]            rd_add;
        logic [3:0]            mem_op;
        logic [1:0]            sel_to_reg;
        logic                  regwrite;
        logic                  rd_en;
        logic                  wr_en;
        logic                  branch;
        logic                  jump;
        logic                  zero;
    } exmem_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU for the execute stage
module alu
    import riscv_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [3:0]            alu_op_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];

    // Operation select; unassigned opcodes produce zero
    always_comb begin
        result_o = '0;
        case (alu_op_i)
            ALU_ADD:    result_o = a_i + b_i;
            ALU_SUB:    result_o = a_i - b_i;
            ALU_SLL:    result_o = a_i << shamt;
            ALU_SLT:    result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:   result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:    result_o = a_i ^ b_i;
            ALU_SRL:    result_o = a_i >> shamt;
            ALU_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:     result_o = a_i | b_i;
            ALU_AND:    result_o = a_i & b_i;
            ALU_PASS_B: result_o = b_i;
            default:    result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, ALU, branch resolution, EX/MEM register
module ex_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] ID_pc_i,
    input  logic [DATA_WIDTH-1:0] ID_imm_i,
    input  logic [DATA_WIDTH-1:0] ID_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] ID_rs2_data_i,
    input  logic [4:0]            ID_rs1_add_i,
    input  logic [4:0]            ID_rs2_add_i,
    input  logic [4:0]            ID_rd_add_i,
    input  logic [3:0]            ID_alu_op_i,
    input  logic [1:0]            ID_alu_sel1_i,
    input  logic [1:0]            ID_alu_sel2_i,
    input  logic [3:0]            ID_mem_op_i,
    input  logic [1:0]            ID_sel_to_reg_i,
    input  logic                  ID_regwrite_i,
    input  logic                  ID_RD_en_i,
    input  logic                  ID_WR_en_i,
    input  logic                  ID_branch_i,
    input  logic                  ID_jump_i,
    input  logic                  ID_pc_sel_i,
    input  logic                  WB_regwrite_i,
    input  logic [4:0]            WB_rd_add_i,
    input  logic [DATA_WIDTH-1:0] WB_data_i,
    output logic                  EX_redirect_o,
    output logic [DATA_WIDTH-1:0] EX_target_o,
    output logic [DATA_WIDTH-1:0] EX_ALU_result_o,
    output logic [DATA_WIDTH-1:0] EX_store_data_o,
    output logic [DATA_WIDTH-1:0] EX_pc4_o,
    output logic [4:0]            EX_rd_add_o,
    output logic [3:0]            EX_mem_op_o,
    output logic [1:0]            EX_sel_to_reg_o,
    output logic                  EX_regwrite_o,
    output logic                  EX_RD_en_o,
    output logic                  EX_WR_en_o,
    output logic                  EX_branch_o,
    output logic                  EX_jump_o,
    output logic                  EX_zero_o
);

    import riscv_pkg::*;

    exmem_t                exmem_d;
    exmem_t                exmem_q;
    logic                  ex_fwd_ok;
    logic                  wb_fwd_ok;
    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic                  br_cond;

    // A load in EX/MEM has no data yet; load-use hazards are stalled upstream
    assign ex_fwd_ok = exmem_q.regwrite & ~exmem_q.rd_en & (exmem_q.rd_add != 5'd0);
    assign wb_fwd_ok = WB_regwrite_i & (WB_rd_add_i != 5'd0);

    // Operand forwarding: x0 reads zero, then the younger EX/MEM result, then WB
    always_comb begin
        rs1_fwd = ID_rs1_data_i;
        if (ID_rs1_add_i == 5'd0)
            rs1_fwd = '0;
        else if (ex_fwd_ok && (exmem_q.rd_add == ID_rs1_add_i))
            rs1_fwd = exmem_q.alu_result;
        else if (wb_fwd_ok && (WB_rd_add_i == ID_rs1_add_i))
            rs1_fwd = WB_data_i;

        rs2_fwd = ID_rs2_data_i;
        if (ID_rs2_add_i == 5'd0)
            rs2_fwd = '0;
        else if (ex_fwd_ok && (exmem_q.rd_add == ID_rs2_add_i))
            rs2_fwd = exmem_q.alu_result;
        else if (wb_fwd_ok && (WB_rd_add_i == ID_rs2_add_i))
            rs2_fwd = WB_data_i;
    end

    // ALU operand selection; unused select codes give constants (0 for A, 4 for B)
    always_comb begin
        case (ID_alu_sel1_i)
            SEL1_RS1: op_a = rs1_fwd;
            SEL1_PC:  op_a = ID_pc_i;
            default:  op_a = '0;
        endcase
        case (ID_alu_sel2_i)
            SEL2_RS2: op_b = rs2_fwd;
            SEL2_IMM: op_b = ID_imm_i;
            default:  op_b = DATA_WIDTH'(4);
        endcase
    end

    alu u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .alu_op_i (ID_alu_op_i),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // Branch condition from funct3 carried in mem_op[2:0]
    always_comb begin
        br_cond = 1'b0;
        case (ID_mem_op_i[2:0])
            BR_BEQ:  br_cond = (rs1_fwd == rs2_fwd);
            BR_BNE:  br_cond = (rs1_fwd != rs2_fwd);
            BR_BLT:  br_cond = ($signed(rs1_fwd) < $signed(rs2_fwd));
            BR_BGE:  br_cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            BR_BLTU: br_cond = (rs1_fwd < rs2_fwd);
            BR_BGEU: br_cond = (rs1_fwd >= rs2_fwd);
            default: br_cond = 1'b0;
        endcase
    end

    assign jalr_sum      = rs1_fwd + ID_imm_i;
    assign EX_target_o   = ID_pc_sel_i ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : (ID_pc_i + ID_imm_i);
    assign EX_redirect_o = ~flush_i & ~stall_i & (ID_jump_i | (ID_branch_i & br_cond));

    // Next EX/MEM contents: stall holds, flush turns the instruction into a bubble
    always_comb begin
        exmem_d = exmem_q;
        if (!stall_i) begin
            exmem_d.alu_result = alu_result;
            exmem_d.store_data = rs2_fwd;
            exmem_d.pc4        = ID_pc_i + DATA_WIDTH'(4);
            exmem_d.rd_add     = ID_rd_add_i;
            exmem_d.mem_op     = ID_mem_op_i;
            exmem_d.sel_to_reg = ID_sel_to_reg_i;
            exmem_d.regwrite   = ID_regwrite_i;
            exmem_d.rd_en      = ID_RD_en_i;
            exmem_d.wr_en      = ID_WR_en_i;
            exmem_d.branch     = ID_branch_i;
            exmem_d.jump       = ID_jump_i;
            exmem_d.zero       = alu_zero;
            if (flush_i) begin
                exmem_d.mem_op     = '0;
                exmem_d.sel_to_reg = '0;
                exmem_d.regwrite   = 1'b0;
                exmem_d.rd_en      = 1'b0;
                exmem_d.wr_en      = 1'b0;
                exmem_d.branch     = 1'b0;
                exmem_d.jump       = 1'b0;
                exmem_d.zero       = 1'b0;
            end
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exmem_q <= '0;
        else
            exmem_q <= exmem_d;
    end

    assign EX_ALU_result_o = exmem_q.alu_result;
    assign EX_store_data_o = exmem_q.store_data;
    assign EX_pc4_o        = exmem_q.pc4;
    assign EX_rd_add_o     = exmem_q.rd_add;
    assign EX_mem_op_o     = exmem_q.mem_op;
    assign EX_sel_to_reg_o = exmem_q.sel_to_reg;
    assign EX_regwrite_o   = exmem_q.regwrite;
    assign EX_RD_en_o      = exmem_q.rd_en;
    assign EX_WR_en_o      = exmem_q.wr_en;
    assign EX_branch_o     = exmem_q.branch;
    assign EX_jump_o       = exmem_q.jump;
    assign EX_zero_o       = exmem_q.zero;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i;
    logic [31:0] ID_pc_i, ID_imm_i, ID_rs1_data_i, ID_rs2_data_i;
    logic [4:0]  ID_rs1_add_i, ID_rs2_add_i, ID_rd_add_i;
    logic [3:0]  ID_alu_op_i, ID_mem_op_i;
    logic [1:0]  ID_alu_sel1_i, ID_alu_sel2_i, ID_sel_to_reg_i;
    logic        ID_regwrite_i, ID_RD_en_i, ID_WR_en_i, ID_branch_i, ID_jump_i, ID_pc_sel_i;
    logic        WB_regwrite_i;
    logic [4:0]  WB_rd_add_i;
    logic [31:0] WB_data_i;
    logic        EX_redirect_o;
    logic [31:0] EX_target_o, EX_ALU_result_o, EX_store_data_o, EX_pc4_o;
    logic [4:0]  EX_rd_add_o;
    logic [3:0]  EX_mem_op_o;
    logic [1:0]  EX_sel_to_reg_o;
    logic        EX_regwrite_o, EX_RD_en_o, EX_WR_en_o, EX_branch_o, EX_jump_o, EX_zero_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_stage #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .ID_pc_i         (ID_pc_i),
        .ID_imm_i        (ID_imm_i),
        .ID_rs1_data_i   (ID_rs1_data_i),
        .ID_rs2_data_i   (ID_rs2_data_i),
        .ID_rs1_add_i    (ID_rs1_add_i),
        .ID_rs2_add_i    (ID_rs2_add_i),
        .ID_rd_add_i     (ID_rd_add_i),
        .ID_alu_op_i     (ID_alu_op_i),
        .ID_alu_sel1_i   (ID_alu_sel1_i),
        .ID_alu_sel2_i   (ID_alu_sel2_i),
        .ID_mem_op_i     (ID_mem_op_i),
        .ID_sel_to_reg_i (ID_sel_to_reg_i),
        .ID_regwrite_i   (ID_regwrite_i),
        .ID_RD_en_i      (ID_RD_en_i),
        .ID_WR_en_i      (ID_WR_en_i),
        .ID_branch_i     (ID_branch_i),
        .ID_jump_i       (ID_jump_i),
        .ID_pc_sel_i     (ID_pc_sel_i),
        .WB_regwrite_i   (WB_regwrite_i),
        .WB_rd_add_i     (WB_rd_add_i),
        .WB_data_i       (WB_data_i),
        .EX_redirect_o   (EX_redirect_o),
        .EX_target_o     (EX_target_o),
        .EX_ALU_result_o (EX_ALU_result_o),
        .EX_store_data_o (EX_store_data_o),
        .EX_pc4_o        (EX_pc4_o),
        .EX_rd_add_o     (EX_rd_add_o),
        .EX_mem_op_o     (EX_mem_op_o),
        .EX_sel_to_reg_o (EX_sel_to_reg_o),
        .EX_regwrite_o   (EX_regwrite_o),
        .EX_RD_en_o      (EX_RD_en_o),
        .EX_WR_en_o      (EX_WR_en_o),
        .EX_branch_o     (EX_branch_o),
        .EX_jump_o       (EX_jump_o),
        .EX_zero_o       (EX_zero_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = 0; flush_i = 0;
        ID_pc_i = 0; ID_imm_i = 0; ID_rs1_data_i = 0; ID_rs2_data_i = 0;
        ID_rs1_add_i = 0; ID_rs2_add_i = 0; ID_rd_add_i = 0;
        ID_alu_op_i = 0; ID_mem_op_i = 0; ID_alu_sel1_i = 0; ID_alu_sel2_i = 0;
        ID_sel_to_reg_i = 0; ID_regwrite_i = 0; ID_RD_en_i = 0; ID_WR_en_i = 0;
        ID_branch_i = 0; ID_jump_i = 0; ID_pc_sel_i = 0;
        WB_regwrite_i = 0; WB_rd_add_i = 0; WB_data_i = 0;
    endtask

    initial begin
        rst_n = 0;
        idle();
        ID_pc_i = 32'h40; ID_regwrite_i = 1; ID_rs1_data_i = 32'h77;
        tick(); tick();
        check("reset_alu", EX_ALU_result_o, 0);
        check("reset_regwrite", {31'd0, EX_regwrite_o}, 0);
        check("reset_pc4", EX_pc4_o, 0);
        rst_n = 1;
        idle();

        // 1: ADD x3 = x1(5) + x2(7)
        ID_rs1_add_i = 1; ID_rs1_data_i = 5; ID_rs2_add_i = 2; ID_rs2_data_i = 7;
        ID_rd_add_i = 3; ID_regwrite_i = 1; ID_alu_op_i = 4'd0; ID_pc_i = 32'h10;
        tick();
        check("add_result", EX_ALU_result_o, 12);
        check("add_zero", {31'd0, EX_zero_o}, 0);
        check("add_rd", {27'd0, EX_rd_add_o}, 3);
        check("add_pc4", EX_pc4_o, 32'h14);

        // 2: x4 = x3 + x3, EX/MEM forward beats stale WB x3=99
        ID_rs1_add_i = 3; ID_rs1_data_i = 0; ID_rs2_add_i = 3; ID_rs2_data_i = 0;
        ID_rd_add_i = 4; WB_regwrite_i = 1; WB_rd_add_i = 3; WB_data_i = 99;
        tick();
        check("fwd_exmem_result", EX_ALU_result_o, 24);
        check("fwd_exmem_store", EX_store_data_o, 12);

        // WB forward on rs1, x0 on rs2 reads zero despite stale register data
        ID_rs1_add_i = 9; ID_rs1_data_i = 1; ID_rs2_add_i = 0; ID_rs2_data_i = 55;
        ID_rd_add_i = 5; WB_rd_add_i = 9; WB_data_i = 100;
        tick();
        check("fwd_wb_result", EX_ALU_result_o, 100);
        check("x0_store", EX_store_data_o, 0);

        // 3: branches
        idle();
        ID_branch_i = 1; ID_alu_op_i = 4'd1;
        ID_rs1_add_i = 10; ID_rs2_add_i = 11; ID_rs1_data_i = 3; ID_rs2_data_i = 3;
        ID_mem_op_i = 4'b0001;
        #1 check("bne_equal_redirect", {31'd0, EX_redirect_o}, 0);
        ID_mem_op_i = 4'b0000;
        #1 check("beq_equal_redirect", {31'd0, EX_redirect_o}, 1);
        ID_mem_op_i = 4'b0010;
        #1 check("code010_redirect", {31'd0, EX_redirect_o}, 0);
        ID_rs1_data_i = 32'hFFFF_FFFF; ID_rs2_data_i = 1; ID_pc_i = 32'h100; ID_imm_i = 16;
        ID_mem_op_i = 4'b0100;
        #1 check("blt_redirect", {31'd0, EX_redirect_o}, 1);
        check("blt_target", EX_target_o, 32'h110);
        ID_mem_op_i = 4'b0110;
        #1 check("bltu_redirect", {31'd0, EX_redirect_o}, 0);
        ID_mem_op_i = 4'b0111;
        #1 check("bgeu_redirect", {31'd0, EX_redirect_o}, 1);
        tick();
        check("branch_reg", {31'd0, EX_branch_o}, 1);
        check("branch_regwrite", {31'd0, EX_regwrite_o}, 0);

        // 4: JALR rs1=0x2001 imm=2
        idle();
        ID_jump_i = 1; ID_pc_sel_i = 1; ID_rs1_add_i = 6; ID_rs1_data_i = 32'h2001;
        ID_imm_i = 2; ID_pc_i = 32'h400; ID_alu_sel1_i = 2'd1; ID_alu_sel2_i = 2'd2;
        ID_rd_add_i = 1; ID_regwrite_i = 1; ID_sel_to_reg_i = 2'd2;
        #1 check("jalr_redirect", {31'd0, EX_redirect_o}, 1);
        check("jalr_target", EX_target_o, 32'h2002);
        tick();
        check("jalr_pc4", EX_pc4_o, 32'h404);
        check("jalr_link", EX_ALU_result_o, 32'h404);
        check("jalr_jump", {31'd0, EX_jump_o}, 1);

        // 5: store, then 3 stalled cycles with a jump waiting, then flush
        idle();
        ID_rs1_add_i = 7; ID_rs1_data_i = 32'h1000; ID_rs2_add_i = 8; ID_rs2_data_i = 32'hDEAD;
        ID_imm_i = 8; ID_alu_sel2_i = 2'd1; ID_WR_en_i = 1; ID_mem_op_i = 4'b0010;
        tick();
        check("store_addr", EX_ALU_result_o, 32'h1008);
        check("store_data", EX_store_data_o, 32'hDEAD);
        idle();
        stall_i = 1; ID_jump_i = 1; ID_pc_i = 32'h500; ID_imm_i = 32'h20;
        ID_regwrite_i = 1; ID_rd_add_i = 2; ID_alu_sel1_i = 2'd1; ID_alu_sel2_i = 2'd2;
        #1 check("stall_redirect", {31'd0, EX_redirect_o}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr", EX_ALU_result_o, 32'h1008);
            check("stall_wr_en", {31'd0, EX_WR_en_o}, 1);
            check("stall_jump", {31'd0, EX_jump_o}, 0);
        end
        stall_i = 0; flush_i = 1;
        #1 check("flush_redirect", {31'd0, EX_redirect_o}, 0);
        tick();
        check("flush_wr_en", {31'd0, EX_WR_en_o}, 0);
        check("flush_regwrite", {31'd0, EX_regwrite_o}, 0);
        check("flush_jump", {31'd0, EX_jump_o}, 0);

        // 6: async reset mid-cycle
        idle();
        ID_rs1_add_i = 1; ID_rs1_data_i = 5; ID_rs2_add_i = 2; ID_rs2_data_i = 7;
        ID_rd_add_i = 3; ID_regwrite_i = 1;
        tick();
        check("pre_reset_result", EX_ALU_result_o, 12);
        #2 rst_n = 0;
        #1;
        check("async_reset_result", EX_ALU_result_o, 0);
        check("async_reset_regwrite", {31'd0, EX_regwrite_o}, 0);
        check("async_reset_rd", {27'd0, EX_rd_add_o}, 0);
        check("async_reset_store", EX_store_data_o, 0);
        ID_jump_i = 1; ID_pc_i = 32'h40; ID_imm_i = 32'h10;
        #1 check("reset_comb_redirect", {31'd0, EX_redirect_o}, 1);
        check("reset_comb_target", EX_target_o, 32'h50);
        #1 rst_n = 1;
        idle();
        ID_rs1_add_i = 1; ID_rs1_data_i = 20; ID_rs2_add_i = 2; ID_rs2_data_i = 22;
        ID_rd_add_i = 6; ID_regwrite_i = 1; ID_sel_to_reg_i = 2'd1;
        tick();
        check("post_reset_result", EX_ALU_result_o, 42);
        check("post_reset_regwrite", {31'd0, EX_regwrite_o}, 1);
        check("post_reset_sel", {30'd0, EX_sel_to_reg_o}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
